i2c_master_reg_seq: RTL and testbench
=====================================

Name: i2c_master_reg_seq

Overview:
- Transaction sequencer directly upstream of the I2C byte controller.
- Accepts one register-access request (7-bit device address, 8-bit register address, write data or read) over a valid/ready handshake.
- Issues the Start/Write/Read/Stop byte-command sequence to the byte controller, checks the ACK after each byte and returns a single response with read data and error flags.

Parameters:
- TIMEOUT_CYCLES, 65535: per-byte watchdog limit in Clk cycles. Used only when I2C_SEQ_TIMEOUT_EN is defined.
- TO_W, 16: watchdog counter width. Must satisfy TIMEOUT_CYCLES <= 2^TO_W-1.

Ports:
- Clk  in  1  system clock
- Rst  in  1  synchronous reset, active-high
- Req_valid  in  1  request present
- Req_ready  out  1  sequencer can accept a request (IDLE only)
- Req_rnw  in  1  1=register read, 0=register write
- Req_dev  in  7  I2C device address
- Req_reg  in  8  register address
- Req_wdata  in  8  write data (ignored for reads)
- Rsp_valid  out  1  response present
- Rsp_ready  in  1  response consumed
- Rsp_rdata  out  8  read data (0x00 for writes and on errors)
- Rsp_nack  out  1  a byte was NACKed
- Rsp_al  out  1  arbitration lost
- Rsp_to  out  1  watchdog expired (always 0 without the macro)
- Start, Stop, Read, Write  out  1 each  byte-controller commands, level, registered
- Tx_ack  out  1  ACK bit sent after a read byte
- Txd_byte  out  8  byte loaded into the transmit shift register
- Rxd_byte  in  8  received byte from the shift register
- I2C_done  in  1  byte-controller completion pulse
- Rx_ack  in  1  ACK sampled from the slave (0=ACK)
- I2C_al  in  1  arbitration lost

Behaviour:
- Rst (sampled on a Clk edge): state=IDLE; all commands=0; Tx_ack=0; Txd_byte=0; Rsp_*=0; Req_ready=1 next cycle.
- A mid-transfer reset leaves the bus unstopped by design.
- Commands are registered and held until the cycle I2C_done=1.
  - In that cycle the next command set is loaded, or all commands go to 0.
  - Commands are therefore never high in the cycle after done unless they form a new command.
- Request handshake: accept on Req_valid & Req_ready, then capture all Req_* fields. Req_ready=0 outside IDLE.
- State machine and next command (each arrow waits for I2C_done):
  - IDLE -> ADDR_W: Start+Write, Txd_byte={dev,0}.
  - ADDR_W -> REG: Write, Txd_byte=reg.
  - REG, write request -> WDATA: Write+Stop, Txd_byte=wdata.
  - REG, read request -> ADDR_R: Start+Write, Txd_byte={dev,1}.
  - ADDR_R -> RDATA: Read+Stop, Tx_ack=1 (NACK on last byte).
  - WDATA, RDATA -> RESP. RDATA latches Rxd_byte into Rsp_rdata on done.
- NACK (Rx_ack=1 at done) in ADDR_W, REG or ADDR_R:
  - Set the nack flag and go to STOP, issuing Stop only.
  - STOP -> RESP on done.
  - A NACK in WDATA sets the flag only; Stop is already issued.
- I2C_al=1 in any busy state:
  - Commands go to 0 in the next cycle; set the al flag; go to RESP. No Stop is issued.
  - I2C_al takes priority over a simultaneous I2C_done.
- RESP: Rsp_valid=1 with flags stable until Rsp_ready; then clear Rsp_valid and return to IDLE.
  - Rsp_ready held high gives 1-cycle response occupancy.
  - Error flags clear on IDLE entry.
- Latency, no wait states in the byte controller: Rsp_valid asserts 1 cycle after the final I2C_done.

Optional Feature:
- I2C_SEQ_TIMEOUT_EN defined:
  - A TO_W-bit counter clears on each command issue and increments every busy cycle.
  - Reaching TIMEOUT_CYCLES forces all commands to 0, sets Rsp_to and goes to RESP.
  - I2C_al has priority over the timeout; I2C_done in the same cycle wins over the timeout.
- Undefined: no counter exists and Rsp_to is tied to 0.

Decomposition:
- Shared package/defines file, alongside the existing I2C defines:
  - sequencer state encodings (IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, STOP, RESP, 3 bits)
  - R/W address-bit constants
- No sub-module; the watchdog stays inline under the macro.

Test Plan:
- Write dev=0x50, reg=0x10, wdata=0xA5, all ACK -> command sequence Start+Write 0xA0, Write 0x10, Write+Stop 0xA5; Rsp_valid with nack=al=to=0, rdata=0x00.
- Read dev=0x50, reg=0x22, slave returns 0x3C -> bytes 0xA0, 0x22, then Start+Write 0xA1, then Read+Stop with Tx_ack=1; Rsp_rdata=0x3C, flags 0.
- Write with Rx_ack=1 on the address byte -> next command is Stop only; Rsp_nack=1; REG/WDATA bytes never issued.
- I2C_al pulsed during REG in the same cycle as I2C_done -> commands 0 next cycle; Rsp_al=1; no Stop; Req_ready=1 after the response handshake.
- Rsp_ready held low for 5 cycles -> Rsp_valid and flags stable; Req_ready=0; Req_valid ignored. Rst asserted mid-REG -> all outputs 0 next cycle; state IDLE.
- With I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20, I2C_done never returned -> commands drop 20 cycles after issue; Rsp_to=1.

Source files
------------

// File: rtl/i2c_master_reg_seq_pkg.sv
// Shared encodings for the I2C register-access sequencer: state codes, R/W address bit
// and the packed byte-controller command set.
package i2c_master_reg_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_ADDR_W = 3'd1,
        SEQ_REG    = 3'd2,
        SEQ_WDATA  = 3'd3,
        SEQ_ADDR_R = 3'd4,
        SEQ_RDATA  = 3'd5,
        SEQ_STOP   = 3'd6,
        SEQ_RESP   = 3'd7
    } seq_state_e;

    localparam logic I2C_ADDR_WR = 1'b0;
    localparam logic I2C_ADDR_RD = 1'b1;

    typedef struct packed {
        logic start;
        logic stop;
        logic read;
        logic write;
    } byte_cmd_t;

    localparam byte_cmd_t CMD_NONE     = '{start: 1'b0, stop: 1'b0, read: 1'b0, write: 1'b0};
    localparam byte_cmd_t CMD_START_WR = '{start: 1'b1, stop: 1'b0, read: 1'b0, write: 1'b1};
    localparam byte_cmd_t CMD_WR       = '{start: 1'b0, stop: 1'b0, read: 1'b0, write: 1'b1};
    localparam byte_cmd_t CMD_WR_STOP  = '{start: 1'b0, stop: 1'b1, read: 1'b0, write: 1'b1};
    localparam byte_cmd_t CMD_RD_STOP  = '{start: 1'b0, stop: 1'b1, read: 1'b1, write: 1'b0};
    localparam byte_cmd_t CMD_STOP     = '{start: 1'b0, stop: 1'b1, read: 1'b0, write: 1'b0};

    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rnw);
        return {dev, rnw};
    endfunction

endpackage

// File: rtl/i2c_master_reg_seq.sv
// Register-access sequencer driving the I2C byte controller with Start/Write/Read/Stop.
// Optional per-byte watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_master_reg_seq
    import i2c_master_reg_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Req_valid,
    output logic       Req_ready,
    input  logic       Req_rnw,
    input  logic [6:0] Req_dev,
    input  logic [7:0] Req_reg,
    input  logic [7:0] Req_wdata,
    output logic       Rsp_valid,
    input  logic       Rsp_ready,
    output logic [7:0] Rsp_rdata,
    output logic       Rsp_nack,
    output logic       Rsp_al,
    output logic       Rsp_to,
    output logic       Start,
    output logic       Stop,
    output logic       Read,
    output logic       Write,
    output logic       Tx_ack,
    output logic [7:0] Txd_byte,
    input  logic [7:0] Rxd_byte,
    input  logic       I2C_done,
    input  logic       Rx_ack,
    input  logic       I2C_al
);

    if (TIMEOUT_CYCLES > 2**TO_W - 1) begin : g_bad_to_cfg
        $error("TIMEOUT_CYCLES does not fit in a TO_W-bit counter");
    end

    seq_state_e state;
    byte_cmd_t  cmd_q;
    logic       rnw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic       busy;
    logic       to_hit;

    assign {Start, Stop, Read, Write} = cmd_q;
    assign busy = (state != SEQ_IDLE) && (state != SEQ_RESP);

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            to_q;
    assign to_hit = busy && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign Rsp_to = to_q;
`else
    assign to_hit = 1'b0;
    assign Rsp_to = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= SEQ_IDLE;
            cmd_q     <= CMD_NONE;
            Tx_ack    <= 1'b0;
            Txd_byte  <= 8'h00;
            Req_ready <= 1'b1;
            Rsp_valid <= 1'b0;
            Rsp_rdata <= 8'h00;
            Rsp_nack  <= 1'b0;
            Rsp_al    <= 1'b0;
            rnw_q     <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
            to_cnt    <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
`ifdef I2C_SEQ_TIMEOUT_EN
            if (busy) to_cnt <= to_cnt + TO_W'(1);
`endif
            case (state)
                SEQ_IDLE: begin
                    if (Req_valid && Req_ready) begin
                        rnw_q     <= Req_rnw;
                        dev_q     <= Req_dev;
                        reg_q     <= Req_reg;
                        wdata_q   <= Req_wdata;
                        Req_ready <= 1'b0;
                        cmd_q     <= CMD_START_WR;
                        Tx_ack    <= 1'b0;
                        Txd_byte  <= addr_byte(Req_dev, I2C_ADDR_WR);
                        state     <= SEQ_ADDR_W;
`ifdef I2C_SEQ_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end
                SEQ_RESP: begin
                    if (Rsp_ready) begin
                        Rsp_valid <= 1'b0;
                        Rsp_rdata <= 8'h00;
                        Rsp_nack  <= 1'b0;
                        Rsp_al    <= 1'b0;
                        Req_ready <= 1'b1;
                        state     <= SEQ_IDLE;
`ifdef I2C_SEQ_TIMEOUT_EN
                        to_q      <= 1'b0;
`endif
                    end
                end
                default: begin
                    // Priority: arbitration loss, then byte completion, then watchdog.
                    if (I2C_al) begin
                        cmd_q     <= CMD_NONE;
                        Tx_ack    <= 1'b0;
                        Rsp_al    <= 1'b1;
                        Rsp_valid <= 1'b1;
                        state     <= SEQ_RESP;
                    end else if (I2C_done) begin
                        cmd_q  <= CMD_NONE;
                        Tx_ack <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        case (state)
                            SEQ_ADDR_W, SEQ_REG, SEQ_ADDR_R: begin
                                if (Rx_ack) begin
                                    Rsp_nack <= 1'b1;
                                    cmd_q    <= CMD_STOP;
                                    state    <= SEQ_STOP;
                                end else if (state == SEQ_ADDR_W) begin
                                    cmd_q    <= CMD_WR;
                                    Txd_byte <= reg_q;
                                    state    <= SEQ_REG;
                                end else if (state == SEQ_ADDR_R) begin
                                    cmd_q    <= CMD_RD_STOP;
                                    Tx_ack   <= 1'b1;
                                    state    <= SEQ_RDATA;
                                end else if (rnw_q) begin
                                    cmd_q    <= CMD_START_WR;
                                    Txd_byte <= addr_byte(dev_q, I2C_ADDR_RD);
                                    state    <= SEQ_ADDR_R;
                                end else begin
                                    cmd_q    <= CMD_WR_STOP;
                                    Txd_byte <= wdata_q;
                                    state    <= SEQ_WDATA;
                                end
                            end
                            SEQ_WDATA: begin
                                if (Rx_ack) Rsp_nack <= 1'b1;
                                Rsp_valid <= 1'b1;
                                state     <= SEQ_RESP;
                            end
                            SEQ_RDATA: begin
                                Rsp_rdata <= Rxd_byte;
                                Rsp_valid <= 1'b1;
                                state     <= SEQ_RESP;
                            end
                            default: begin
                                Rsp_valid <= 1'b1;
                                state     <= SEQ_RESP;
                            end
                        endcase
                    end else if (to_hit) begin
                        cmd_q     <= CMD_NONE;
                        Tx_ack    <= 1'b0;
                        Rsp_valid <= 1'b1;
                        state     <= SEQ_RESP;
`ifdef I2C_SEQ_TIMEOUT_EN
                        to_q      <= 1'b1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_reg_seq.sv
// Self-checking bench for i2c_master_reg_seq: table vectors, random transactions against a
// transaction-level model, plus reset, response-stall and (with I2C_SEQ_TIMEOUT_EN) watchdog cases.
module tb_i2c_master_reg_seq;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Req_valid, Req_ready, Req_rnw;
    logic [6:0] Req_dev;
    logic [7:0] Req_reg, Req_wdata;
    logic       Rsp_valid, Rsp_ready;
    logic [7:0] Rsp_rdata;
    logic       Rsp_nack, Rsp_al, Rsp_to;
    logic       Start, Stop, Read, Write, Tx_ack;
    logic [7:0] Txd_byte, Rxd_byte;
    logic       I2C_done, Rx_ack, I2C_al;

    always #5 Clk = ~Clk;

    i2c_master_reg_seq #(.TIMEOUT_CYCLES(20), .TO_W(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_rnw(Req_rnw),
        .Req_dev(Req_dev), .Req_reg(Req_reg), .Req_wdata(Req_wdata),
        .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready), .Rsp_rdata(Rsp_rdata),
        .Rsp_nack(Rsp_nack), .Rsp_al(Rsp_al), .Rsp_to(Rsp_to),
        .Start(Start), .Stop(Stop), .Read(Read), .Write(Write),
        .Tx_ack(Tx_ack), .Txd_byte(Txd_byte), .Rxd_byte(Rxd_byte),
        .I2C_done(I2C_done), .Rx_ack(Rx_ack), .I2C_al(I2C_al)
    );

    typedef struct {
        logic       rnw;
        logic [6:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
        logic [7:0] rx;
        int         nack_idx;
        int         al_idx;
        int         hold;
        int         exp_ncmds;
        logic [7:0] exp_rdata;
        logic       exp_nack;
        logic       exp_al;
    } vec_t;

    vec_t        vecs[8];
    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [12:0] exp_cmds[$];
    logic [12:0] got_cmds[$];
    logic [7:0]  exp_rdata;
    logic        exp_nack, exp_al;

    // Command word {start, stop, read, write, tx_ack, txd}; don't-care fields forced to 0.
    function automatic logic [12:0] mk_cmd(input logic s, input logic p, input logic r,
                                           input logic w, input logic ack, input logic [7:0] txd);
        return {s, p, r, w, r ? ack : 1'b0, w ? txd : 8'h00};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: list of byte phases, cut short by NACK or arbitration loss.
    task automatic run_model(input vec_t v);
        logic [12:0] phases[$];
        exp_cmds.delete();
        exp_rdata = 8'h00;
        exp_nack  = 1'b0;
        exp_al    = 1'b0;
        phases.push_back(mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {v.dev, 1'b0}));
        phases.push_back(mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v.reg_addr));
        if (v.rnw) begin
            phases.push_back(mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {v.dev, 1'b1}));
            phases.push_back(mk_cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00));
        end else begin
            phases.push_back(mk_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, v.wdata));
        end
        for (int i = 0; i < phases.size(); i++) begin
            exp_cmds.push_back(phases[i]);
            if (v.al_idx == i) begin
                exp_al = 1'b1;
                return;
            end
            if (v.nack_idx == i && !phases[i][10]) begin
                exp_nack = 1'b1;
                if (!phases[i][11]) begin
                    exp_cmds.push_back(mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
                    if (v.al_idx == i + 1) exp_al = 1'b1;
                end
                return;
            end
            if (phases[i][10]) exp_rdata = v.rx;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit use_table);
        int b, guard, gaps, d;
        run_model(v);
        got_cmds.delete();
        @(negedge Clk);
        checkOutput("req_ready_idle", 32'(Req_ready), 1);
        Req_valid = 1'b1;
        Req_rnw   = v.rnw;
        Req_dev   = v.dev;
        Req_reg   = v.reg_addr;
        Req_wdata = v.wdata;
        @(negedge Clk);
        Req_valid = 1'b0;
        Req_dev   = 7'($urandom);
        Req_reg   = 8'($urandom);
        Req_wdata = 8'($urandom);
        b = 0; guard = 0; gaps = 0;
        while (!Rsp_valid && guard < 200) begin
            guard++;
            if ({Start, Stop, Read, Write} != 4'b0000) begin
                got_cmds.push_back(mk_cmd(Start, Stop, Read, Write, Tx_ack, Txd_byte));
                d = int'($urandom_range(0, 3));
                repeat (d) @(negedge Clk);
                I2C_done = 1'b1;
                Rx_ack   = (b == v.nack_idx);
                I2C_al   = (b == v.al_idx);
                Rxd_byte = v.rx;
                @(negedge Clk);
                I2C_done = 1'b0;
                Rx_ack   = 1'b0;
                I2C_al   = 1'b0;
                Rxd_byte = 8'($urandom);
                b++;
            end else begin
                gaps++;
                @(negedge Clk);
            end
        end
        checkOutput("rsp_valid_seen", 32'(Rsp_valid), 1);
        checkOutput("idle_gap_cycles", 32'(gaps), 0);
        checkOutput("ncmds_model", 32'(got_cmds.size()), 32'(exp_cmds.size()));
        for (int i = 0; i < got_cmds.size() && i < exp_cmds.size(); i++)
            checkOutput($sformatf("cmd%0d", i), 32'(got_cmds[i]), 32'(exp_cmds[i]));
        checkOutput("rsp_rdata", 32'(Rsp_rdata), 32'(exp_rdata));
        checkOutput("rsp_nack", 32'(Rsp_nack), 32'(exp_nack));
        checkOutput("rsp_al", 32'(Rsp_al), 32'(exp_al));
        checkOutput("rsp_to", 32'(Rsp_to), 0);
        if (use_table) begin
            checkOutput("ncmds_table", 32'(got_cmds.size()), 32'(v.exp_ncmds));
            checkOutput("rdata_table", 32'(Rsp_rdata), 32'(v.exp_rdata));
            checkOutput("nack_table", 32'(Rsp_nack), 32'(v.exp_nack));
            checkOutput("al_table", 32'(Rsp_al), 32'(v.exp_al));
        end
        // Stall the response with a competing request pending; nothing may move.
        for (int k = 0; k < v.hold; k++) begin
            Req_valid = 1'b1;
            Req_rnw   = 1'($urandom);
            @(negedge Clk);
            checkOutput("hold_valid", 32'(Rsp_valid), 1);
            checkOutput("hold_req_ready", 32'(Req_ready), 0);
            checkOutput("hold_rdata", 32'(Rsp_rdata), 32'(exp_rdata));
            checkOutput("hold_flags", 32'({Rsp_nack, Rsp_al}), 32'({exp_nack, exp_al}));
        end
        Req_valid = 1'b0;
        Rsp_ready = 1'b1;
        @(negedge Clk);
        Rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", 32'(Rsp_valid), 0);
        checkOutput("post_req_ready", 32'(Req_ready), 1);
        checkOutput("post_flags", 32'({Rsp_nack, Rsp_al, Rsp_to}), 0);
        checkOutput("post_cmds", 32'({Start, Stop, Read, Write}), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t rv;
        int   cnt;

        vecs[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, -1, 5, 3, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, -1, -1, 0, 4, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00,  0, -1, 1, 2, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 7'h2B, 8'h01, 8'h77, 8'h00, -1,  1, 2, 2, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00,  2, -1, 0, 3, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 7'h00, 8'h80, 8'h00, 8'h99,  2, -1, 3, 4, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 7'h11, 8'h44, 8'h00, 8'h5A, -1,  3, 0, 4, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 7'h3E, 8'h02, 8'h00, 8'h12,  1,  2, 1, 3, 8'h00, 1'b1, 1'b1};

        Rst = 1'b1;
        Req_valid = 1'b0; Req_rnw = 1'b0; Req_dev = 7'h00; Req_reg = 8'h00; Req_wdata = 8'h00;
        Rsp_ready = 1'b0; Rxd_byte = 8'h00; I2C_done = 1'b0; Rx_ack = 1'b0; I2C_al = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        $display("[TB] reset state");
        checkOutput("rst_req_ready", 32'(Req_ready), 1);
        checkOutput("rst_cmds", 32'({Start, Stop, Read, Write, Tx_ack}), 0);
        checkOutput("rst_txd", 32'(Txd_byte), 0);
        checkOutput("rst_rsp", 32'({Rsp_valid, Rsp_nack, Rsp_al, Rsp_to, Rsp_rdata}), 0);

        $display("[TB] table vectors");
        foreach (vecs[i]) applyStimulus(vecs[i], 1'b1);

        $display("[TB] reset during REG byte");
        @(negedge Clk);
        Req_valid = 1'b1; Req_rnw = 1'b0; Req_dev = 7'h50; Req_reg = 8'h10; Req_wdata = 8'hA5;
        @(negedge Clk);
        Req_valid = 1'b0;
        I2C_done = 1'b1; Rx_ack = 1'b0;
        @(negedge Clk);
        I2C_done = 1'b0;
        checkOutput("midreg_cmd", 32'(mk_cmd(Start, Stop, Read, Write, Tx_ack, Txd_byte)),
                    32'(mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10)));
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checkOutput("midrst_cmds", 32'({Start, Stop, Read, Write, Tx_ack}), 0);
        checkOutput("midrst_txd", 32'(Txd_byte), 0);
        checkOutput("midrst_rsp", 32'({Rsp_valid, Rsp_nack, Rsp_al, Rsp_to, Rsp_rdata}), 0);
        checkOutput("midrst_req_ready", 32'(Req_ready), 1);
        applyStimulus(vecs[1], 1'b1);

`ifdef I2C_SEQ_TIMEOUT_EN
        $display("[TB] watchdog with no byte completion");
        @(negedge Clk);
        Req_valid = 1'b1; Req_rnw = 1'b1; Req_dev = 7'h21; Req_reg = 8'h05;
        @(negedge Clk);
        Req_valid = 1'b0;
        cnt = 0;
        while ({Start, Stop, Read, Write} != 4'b0000 && cnt < 100) begin
            @(negedge Clk);
            cnt++;
        end
        checkOutput("to_drop_cycles", 32'(cnt), 20);
        checkOutput("to_valid", 32'(Rsp_valid), 1);
        checkOutput("to_flag", 32'(Rsp_to), 1);
        checkOutput("to_other_flags", 32'({Rsp_nack, Rsp_al, Rsp_rdata}), 0);
        Rsp_ready = 1'b1;
        @(negedge Clk);
        Rsp_ready = 1'b0;
        checkOutput("to_cleared", 32'({Rsp_valid, Rsp_to}), 0);
`endif

        $display("[TB] random transactions");
        for (int n = 0; n < 40; n++) begin
            rv.rnw      = 1'($urandom);
            rv.dev      = 7'($urandom);
            rv.reg_addr = 8'($urandom);
            rv.wdata    = 8'($urandom);
            rv.rx       = 8'($urandom);
            rv.nack_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            rv.al_idx   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
            rv.hold     = int'($urandom_range(0, 3));
            rv.exp_ncmds = 0;
            rv.exp_rdata = 8'h00;
            rv.exp_nack  = 1'b0;
            rv.exp_al    = 1'b0;
            applyStimulus(rv, 1'b0);
        end

        cnt = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
